// File: rtl/acc_cpu_mc.sv
// Multicycle accumulator CPU: fetches over a req/ack instruction port, executes on a
// DATA_W accumulator with Z/C flags, and drives a valid/ready output port.
module acc_cpu_mc #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ADDR_W  = 8,
    localparam int unsigned INSTR_W = 4 + DATA_W
) (
    input  logic               clk,
    input  logic               reset,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic               imem_req,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  acc,
    output logic               halted
);

    localparam logic [1:0] StFetch   = 2'd0;
    localparam logic [1:0] StExec    = 2'd1;
    localparam logic [1:0] StOutWait = 2'd2;
    localparam logic [1:0] StHalted  = 2'd3;

    localparam logic [3:0] OpNop  = 4'h0;
    localparam logic [3:0] OpLdi  = 4'h1;
    localparam logic [3:0] OpAdd  = 4'h2;
    localparam logic [3:0] OpSub  = 4'h3;
    localparam logic [3:0] OpAnd  = 4'h4;
    localparam logic [3:0] OpOr   = 4'h5;
    localparam logic [3:0] OpXor  = 4'h6;
    localparam logic [3:0] OpShl  = 4'h7;
    localparam logic [3:0] OpShr  = 4'h8;
    localparam logic [3:0] OpJmp  = 4'h9;
    localparam logic [3:0] OpJz   = 4'hA;
    localparam logic [3:0] OpJc   = 4'hB;
    localparam logic [3:0] OpOut  = 4'hC;
    localparam logic [3:0] OpHalt = 4'hF;

    logic [1:0]         state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [DATA_W-1:0]  acc_q, acc_d;
    logic               z_q, z_d;
    logic               c_q, c_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0]  out_data_q, out_data_d;

    logic [3:0]         opcode;
    logic [DATA_W-1:0]  imm;
    logic [ADDR_W-1:0]  jmp_target;
    logic [ADDR_W-1:0]  pc_inc;
    logic [DATA_W:0]    sum;
    logic [DATA_W:0]    diff;
    logic [DATA_W-1:0]  acc_new;
    logic               acc_wr;

    assign opcode     = ir_q[INSTR_W-1:DATA_W];
    assign imm        = ir_q[DATA_W-1:0];
    assign jmp_target = imm[ADDR_W-1:0];
    assign pc_inc     = pc_q + ADDR_W'(1);
    assign sum        = {1'b0, acc_q} + {1'b0, imm};
    // Bit DATA_W of the widened difference is the borrow (imm > acc unsigned).
    assign diff       = {1'b0, acc_q} - {1'b0, imm};

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        acc_d      = acc_q;
        z_d        = z_q;
        c_d        = c_q;
        ir_d       = ir_q;
        out_data_d = out_data_q;
        acc_new    = acc_q;
        acc_wr     = 1'b0;

        case (state_q)
            StFetch: begin
                if (imem_ack) begin
                    ir_d    = imem_data;
                    state_d = StExec;
                end
            end
            StExec: begin
                pc_d    = pc_inc;
                state_d = StFetch;
                case (opcode)
                    OpLdi: begin
                        acc_new = imm;
                        acc_wr  = 1'b1;
                    end
                    OpAdd: begin
                        acc_new = sum[DATA_W-1:0];
                        c_d     = sum[DATA_W];
                        acc_wr  = 1'b1;
                    end
                    OpSub: begin
                        acc_new = diff[DATA_W-1:0];
                        c_d     = diff[DATA_W];
                        acc_wr  = 1'b1;
                    end
                    OpAnd: begin
                        acc_new = acc_q & imm;
                        acc_wr  = 1'b1;
                    end
                    OpOr: begin
                        acc_new = acc_q | imm;
                        acc_wr  = 1'b1;
                    end
                    OpXor: begin
                        acc_new = acc_q ^ imm;
                        acc_wr  = 1'b1;
                    end
                    OpShl: begin
                        acc_new = {acc_q[DATA_W-2:0], 1'b0};
                        c_d     = acc_q[DATA_W-1];
                        acc_wr  = 1'b1;
                    end
                    OpShr: begin
                        acc_new = {1'b0, acc_q[DATA_W-1:1]};
                        c_d     = acc_q[0];
                        acc_wr  = 1'b1;
                    end
                    OpJmp: pc_d = jmp_target;
                    OpJz: begin
                        if (z_q) pc_d = jmp_target;
                    end
                    OpJc: begin
                        if (c_q) pc_d = jmp_target;
                    end
                    OpOut: begin
                        out_data_d = acc_q;
                        state_d    = StOutWait;
                    end
                    OpHalt: begin
                        pc_d    = pc_q;
                        state_d = StHalted;
                    end
                    default: ;  // NOP and unused opcodes D, E
                endcase
                if (acc_wr) begin
                    acc_d = acc_new;
                    z_d   = (acc_new == '0);
                end
            end
            StOutWait: begin
                if (out_ready) state_d = StFetch;
            end
            default: state_d = StHalted;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StFetch;
            pc_q       <= '0;
            acc_q      <= '0;
            z_q        <= 1'b0;
            c_q        <= 1'b0;
            ir_q       <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            acc_q      <= acc_d;
            z_q        <= z_d;
            c_q        <= c_d;
            ir_q       <= ir_d;
            out_data_q <= out_data_d;
        end
    end

    // Handshake outputs decode from registered state only.
    assign imem_addr = pc_q;
    assign imem_req  = (state_q == StFetch);
    assign out_valid = (state_q == StOutWait);
    assign halted    = (state_q == StHalted);
    assign out_data  = out_data_q;
    assign acc       = acc_q;

endmodule

// File: tb/tb_acc_cpu_mc.sv
// Directed bench for acc_cpu_mc: behavioural instruction memory with programmable ack delay,
// per-feature tasks with hand-computed expectations.
module tb_acc_cpu_mc;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned INSTR_W = 12;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_req;
    logic               imem_ack = 1'b0;
    logic [INSTR_W-1:0] imem_data = '0;
    logic [DATA_W-1:0]  out_data;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [DATA_W-1:0]  acc;
    logic               halted;

    int n_checks = 0;
    int n_fail   = 0;

    logic [INSTR_W-1:0] mem [0:255];
    int ack_delay = 0;
    int wait_cnt  = 0;
    int fetch_cnt = 0;
    int xfer_cnt  = 0;

    acc_cpu_mc #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .imem_addr (imem_addr),
        .imem_req  (imem_req),
        .imem_ack  (imem_ack),
        .imem_data (imem_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc       (acc),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    // Memory model: decides ack shortly after each falling edge, for the next rising edge.
    always @(negedge clk) begin
        #1;
        if (reset || !imem_req) begin
            imem_ack = 1'b0;
            wait_cnt = 0;
        end else if (wait_cnt >= ack_delay) begin
            imem_ack  = 1'b1;
            imem_data = mem[imem_addr];
            wait_cnt  = 0;
        end else begin
            imem_ack = 1'b0;
            wait_cnt++;
        end
    end

    always @(posedge clk) begin
        if (!reset && imem_req && imem_ack) fetch_cnt++;
        if (!reset && out_valid && out_ready) xfer_cnt++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [INSTR_W-1:0] ins(input logic [3:0] op, input logic [7:0] imm);
        return {op, imm};
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        step(2);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        clear_mem();
        mem[0] = ins(4'h1, 8'h11);
        mem[1] = ins(4'h1, 8'h22);
        mem[2] = ins(4'hF, 8'h00);
        do_reset();
        n_checks++; if (imem_addr !== 8'h00) begin n_fail++; $display("FAIL reset_addr: got %h want 00", imem_addr); end
        n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL reset_req: got %b want 1", imem_req); end
        n_checks++; if (acc !== 8'h00) begin n_fail++; $display("FAIL reset_acc: got %h want 00", acc); end
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b want 0", halted); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_odata: got %h want 00", out_data); end
        step(1);
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL exec_req: got %b want 0", imem_req); end
        step(1);
        n_checks++; if (imem_addr !== 8'h01) begin n_fail++; $display("FAIL retire1_addr: got %h want 01", imem_addr); end
        n_checks++; if (acc !== 8'h11) begin n_fail++; $display("FAIL retire1_acc: got %h want 11", acc); end
        step(2);
        n_checks++; if (imem_addr !== 8'h02) begin n_fail++; $display("FAIL retire2_addr: got %h want 02", imem_addr); end
        n_checks++; if (acc !== 8'h22) begin n_fail++; $display("FAIL retire2_acc: got %h want 22", acc); end
    endtask

    // Flags are observed through the branch each op is followed by.
    task automatic test_arith();
        logic [7:0] ea [0:14];
        logic [7:0] ep [0:14];
        clear_mem();
        mem[8'h00] = ins(4'h1, 8'hF0);  mem[8'h01] = ins(4'h2, 8'h20);
        mem[8'h02] = ins(4'hB, 8'h04);  mem[8'h03] = ins(4'hF, 8'h00);
        mem[8'h04] = ins(4'hA, 8'h03);  mem[8'h05] = ins(4'h3, 8'h10);
        mem[8'h06] = ins(4'hA, 8'h08);  mem[8'h07] = ins(4'hF, 8'h00);
        mem[8'h08] = ins(4'hB, 8'h07);  mem[8'h09] = ins(4'h3, 8'h01);
        mem[8'h0A] = ins(4'hB, 8'h0C);  mem[8'h0B] = ins(4'hF, 8'h00);
        mem[8'h0C] = ins(4'h8, 8'h00);  mem[8'h0D] = ins(4'hB, 8'h0F);
        mem[8'h0E] = ins(4'hF, 8'h00);  mem[8'h0F] = ins(4'h4, 8'h00);
        mem[8'h10] = ins(4'hB, 8'h12);  mem[8'h11] = ins(4'hF, 8'h00);
        mem[8'h12] = ins(4'hA, 8'h14);  mem[8'h13] = ins(4'hF, 8'h00);
        mem[8'h14] = ins(4'hF, 8'h00);
        ea = '{8'hF0, 8'h10, 8'h10, 8'h10, 8'h00, 8'h00, 8'h00, 8'hFF,
               8'hFF, 8'h7F, 8'h7F, 8'h00, 8'h00, 8'h00, 8'h00};
        ep = '{8'h01, 8'h02, 8'h04, 8'h05, 8'h06, 8'h08, 8'h09, 8'h0A,
               8'h0C, 8'h0D, 8'h0F, 8'h10, 8'h12, 8'h14, 8'h14};
        do_reset();
        for (int i = 0; i < 15; i++) begin
            step(2);
            n_checks++;
            if (acc !== ea[i]) begin n_fail++; $display("FAIL arith_acc[%0d]: got %h want %h", i, acc, ea[i]); end
            n_checks++;
            if (imem_addr !== ep[i]) begin n_fail++; $display("FAIL arith_pc[%0d]: got %h want %h", i, imem_addr, ep[i]); end
        end
        n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL arith_halted: got %b want 1", halted); end
    endtask

    task automatic test_logic();
        logic [7:0] ea [0:6];
        logic [7:0] ep [0:6];
        clear_mem();
        mem[0] = ins(4'h1, 8'h0C);  mem[1] = ins(4'h5, 8'h30);
        mem[2] = ins(4'h6, 8'hFF);  mem[3] = ins(4'h7, 8'h00);
        mem[4] = ins(4'hB, 8'h06);  mem[5] = ins(4'hF, 8'h00);
        mem[6] = ins(4'h2, 8'h7A);  mem[7] = ins(4'hA, 8'h09);
        mem[8] = ins(4'hF, 8'h00);  mem[9] = ins(4'hF, 8'h00);
        ea = '{8'h0C, 8'h3C, 8'hC3, 8'h86, 8'h86, 8'h00, 8'h00};
        ep = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h06, 8'h07, 8'h09};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            step(2);
            n_checks++;
            if (acc !== ea[i]) begin n_fail++; $display("FAIL logic_acc[%0d]: got %h want %h", i, acc, ea[i]); end
            n_checks++;
            if (imem_addr !== ep[i]) begin n_fail++; $display("FAIL logic_pc[%0d]: got %h want %h", i, imem_addr, ep[i]); end
        end
    endtask

    task automatic test_branch();
        logic [7:0] ea [0:6];
        logic [7:0] ep [0:6];
        clear_mem();
        mem[8'h00] = ins(4'h1, 8'h00);  mem[8'h01] = ins(4'hA, 8'h10);
        mem[8'h10] = ins(4'h1, 8'h01);  mem[8'h11] = ins(4'hA, 8'h30);
        mem[8'h12] = ins(4'hB, 8'h40);  mem[8'h13] = ins(4'h9, 8'hFF);
        mem[8'hFF] = ins(4'h0, 8'h00);
        ea = '{8'h00, 8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
        ep = '{8'h01, 8'h10, 8'h11, 8'h12, 8'h13, 8'hFF, 8'h00};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            step(2);
            n_checks++;
            if (acc !== ea[i]) begin n_fail++; $display("FAIL branch_acc[%0d]: got %h want %h", i, acc, ea[i]); end
            n_checks++;
            if (imem_addr !== ep[i]) begin n_fail++; $display("FAIL branch_pc[%0d]: got %h want %h", i, imem_addr, ep[i]); end
        end
    endtask

    task automatic test_stall();
        int base;
        clear_mem();
        mem[0] = ins(4'h1, 8'h05);
        mem[1] = ins(4'h2, 8'h03);
        mem[2] = ins(4'hF, 8'h00);
        ack_delay = 3;
        do_reset();
        base = fetch_cnt;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (imem_req !== 1'b1) begin n_fail++; $display("FAIL stall_req[%0d]: got %b want 1", i, imem_req); end
            n_checks++;
            if (imem_addr !== 8'h00) begin n_fail++; $display("FAIL stall_addr[%0d]: got %h want 00", i, imem_addr); end
            step(1);
        end
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_exec: got %b want 0", imem_req); end
        step(1);
        n_checks++; if (acc !== 8'h05) begin n_fail++; $display("FAIL stall_acc1: got %h want 05", acc); end
        n_checks++; if (imem_addr !== 8'h01) begin n_fail++; $display("FAIL stall_pc1: got %h want 01", imem_addr); end
        step(5);
        n_checks++; if (acc !== 8'h08) begin n_fail++; $display("FAIL stall_acc2: got %h want 08", acc); end
        n_checks++; if (imem_addr !== 8'h02) begin n_fail++; $display("FAIL stall_pc2: got %h want 02", imem_addr); end
        n_checks++; if (fetch_cnt - base !== 2) begin n_fail++; $display("FAIL stall_fetches: got %0d want 2", fetch_cnt - base); end
        ack_delay = 0;
    endtask

    task automatic test_out();
        int fbase;
        int xbase;
        clear_mem();
        mem[0] = ins(4'h1, 8'h5A);
        mem[1] = ins(4'hC, 8'h00);
        mem[2] = ins(4'hF, 8'h00);
        out_ready = 1'b0;
        do_reset();
        fbase = fetch_cnt;
        xbase = xfer_cnt;
        step(4);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (out_valid !== 1'b1) begin n_fail++; $display("FAIL out_valid[%0d]: got %b want 1", i, out_valid); end
            n_checks++;
            if (out_data !== 8'h5A) begin n_fail++; $display("FAIL out_data[%0d]: got %h want 5a", i, out_data); end
            n_checks++;
            if (imem_req !== 1'b0) begin n_fail++; $display("FAIL out_noreq[%0d]: got %b want 0", i, imem_req); end
            if (i < 3) step(1);
        end
        n_checks++; if (fetch_cnt - fbase !== 2) begin n_fail++; $display("FAIL out_fetches: got %0d want 2", fetch_cnt - fbase); end
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL out_drop: got %b want 0", out_valid); end
        n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL out_refetch_req: got %b want 1", imem_req); end
        n_checks++; if (imem_addr !== 8'h02) begin n_fail++; $display("FAIL out_refetch_pc: got %h want 02", imem_addr); end
        n_checks++; if (xfer_cnt - xbase !== 1) begin n_fail++; $display("FAIL out_xfers: got %0d want 1", xfer_cnt - xbase); end
    endtask

    task automatic test_halt();
        clear_mem();
        mem[0] = ins(4'h1, 8'h3C);
        mem[1] = ins(4'hD, 8'h77);
        mem[2] = ins(4'hE, 8'h11);
        mem[3] = ins(4'hF, 8'h00);
        mem[4] = ins(4'h1, 8'hAA);
        do_reset();
        step(8);
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_flag[%0d]: got %b want 1", i, halted); end
            n_checks++;
            if (imem_req !== 1'b0) begin n_fail++; $display("FAIL halt_req[%0d]: got %b want 0", i, imem_req); end
            n_checks++;
            if (imem_addr !== 8'h03) begin n_fail++; $display("FAIL halt_pc[%0d]: got %h want 03", i, imem_addr); end
            n_checks++;
            if (acc !== 8'h3C) begin n_fail++; $display("FAIL halt_acc[%0d]: got %h want 3c", i, acc); end
            step(10);
        end
    endtask

    task automatic test_reset_out();
        int xbase;
        clear_mem();
        mem[0] = ins(4'h1, 8'h77);
        mem[1] = ins(4'hC, 8'h00);
        out_ready = 1'b0;
        do_reset();
        step(4);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rst_out_pre: got %b want 1", out_valid); end
        xbase = xfer_cnt;
        reset = 1'b1;
        out_ready = 1'b1;
        step(1);
        reset = 1'b0;
        out_ready = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        n_checks++; if (acc !== 8'h00) begin n_fail++; $display("FAIL rst_out_acc: got %h want 00", acc); end
        n_checks++; if (imem_addr !== 8'h00) begin n_fail++; $display("FAIL rst_out_pc: got %h want 00", imem_addr); end
        n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL rst_out_req: got %b want 1", imem_req); end
        n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL rst_out_data: got %h want 00", out_data); end
        n_checks++; if (xfer_cnt - xbase !== 0) begin n_fail++; $display("FAIL rst_out_xfer: got %0d want 0", xfer_cnt - xbase); end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_logic();
        test_branch();
        test_stall();
        test_out();
        test_halt();
        test_reset_out();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/acc_cpu_mc.md
# acc_cpu_mc

Parametrised multicycle successor to the team's single-cycle accumulator CPU. Fetches instructions from an external instruction memory over a req/ack handshake and executes them on a DATA_W accumulator with zero and carry flags. Supports conditional branches and a handshaked output port. Sits at the top of the processor subsystem; instruction memory and output sink are external.

## Interface
- DATA_W, 8: accumulator and immediate width (≥4).
- ADDR_W, 8: program counter width (ADDR_W ≤ DATA_W); INSTR_W = 4 + DATA_W.
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_addr  out  ADDR_W  fetch address (= pc).
- imem_req  out  1  fetch request.
- imem_ack  in  1  imem_data valid this cycle.
- imem_data  in  INSTR_W  instruction {opcode[3:0], imm[DATA_W-1:0]}.
- out_data  out  DATA_W  OUT payload.
- out_valid  out  1  out_data valid.
- out_ready  in  1  sink accepts out_data.
- acc  out  DATA_W  current accumulator (debug).
- halted  out  1  CPU in HALTED state.

## Operation
- Opcodes: 0 NOP; 1 LDI acc=imm; 2 ADD acc=acc+imm, C=carry-out; 3 SUB acc=acc−imm, C=borrow (1 when imm>acc unsigned); 4 AND; 5 OR; 6 XOR (acc op imm); 7 SHL acc=acc<<1, C=old msb; 8 SHR logical, C=old lsb; 9 JMP pc=imm[ADDR_W-1:0]; A JZ jump if Z; B JC jump if C; C OUT; F HALT; D, E execute as NOP.
- Arithmetic mod 2^DATA_W. Z = (new acc == 0) on every acc-writing op (1–8). C written only by 2, 3, 7, 8; LDI/logic ops leave C unchanged. Branches, NOP, OUT, HALT change no flags.
- pc increments mod 2^ADDR_W (wraps 2^ADDR_W−1 → 0) unless a jump is taken.
- FSM states: FETCH, EXEC, OUT_WAIT, HALTED.
  - FETCH: imem_req=1, imem_addr=pc. On imem_ack: latch imem_data into IR → EXEC. No ack → stay, req held, addr stable.
  - EXEC: one cycle; update acc/flags/pc per IR. OUT → latch out_data=acc, → OUT_WAIT. HALT → HALTED (pc not incremented). Otherwise → FETCH.
  - OUT_WAIT: out_valid=1, out_data stable; on out_ready → out_valid drops next cycle, → FETCH.
  - HALTED: terminal; halted=1, imem_req=0; left only by reset.
- imem_ack outside FETCH is ignored. out_ready while out_valid=0 is ignored.

## Timing
- Reset values (cycle after reset sampled): state FETCH, pc=0, acc=0, Z=0, C=0, IR=0, out_data=0, out_valid=0, halted=0, imem_addr=0. imem_req=1 from first post-reset cycle.
- imem_req, out_valid, halted decode from registered state (no combinational input→output path).
- Minimum 2 cycles/instruction (ack same cycle as req). Each cycle of ack delay adds one FETCH cycle.
- OUT: ≥3 cycles (FETCH, EXEC, ≥1 OUT_WAIT); out_ready already high → transfer in first OUT_WAIT cycle.
- acc/flag/pc updates visible the cycle after EXEC.
- Reset mid-fetch or mid-OUT_WAIT: request/valid abandoned; all state to reset values next cycle; no transfer counted.
- Reset has priority over every other event, including imem_ack or out_ready in the same cycle.

## Test plan
- Reset/fetch: hold reset 2 cycles, release, ack same-cycle → imem_addr=0, imem_req=1 first cycle; instructions retire every 2 cycles; acc=0, halted=0 after reset.
- Arithmetic/flags (DATA_W=8): LDI 0xF0, ADD 0x20 → acc=0x10, C=1, Z=0; SUB 0x10 → acc=0, Z=1, C=0; SUB 0x01 → acc=0xFF, C=1; SHR → acc=0x7F, C=1; AND 0x00 → Z=1, C unchanged.
- Branches: LDI 0, JZ 0x10 → next imem_addr=0x10; LDI 1, JZ 0x10 → falls through pc+1; JC with C=0 not taken; JMP 0xFF then NOP → pc wraps to 0x00.
- Fetch stall: ack delayed 3 cycles → req and imem_addr stable throughout, instruction executes once, acc correct.
- OUT handshake: LDI 0x5A, OUT with out_ready low 4 cycles → out_valid=1, out_data=0x5A stable, no fetch issued; ready high → exactly one transfer, FETCH of pc+1 next cycle.
- HALT/reset: HALT at addr 3 → halted=1, imem_req=0 indefinitely, imem_addr=3; reset during OUT_WAIT → out_valid=0, pc=0, acc=0 next cycle.
